// File: rtl/approx_adder_pipe_errmon.sv
// approx_adder_pipe_errmon
// Two-stage pipelined lower-part-OR approximate adder with an exact reference
// sum computed alongside, per-sample error magnitude / threshold flag, and
// running statistics (sample count, violation count, max error).
//
// Handshake: a transfer happens on a port in any cycle where valid && ready
// are both high at the rising clock edge. A producer holds valid and data
// stable until that transfer; ready may depend combinationally on the
// downstream ready (in_ready follows out_ready when the pipe is full).
module approx_adder_pipe_errmon #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 2,
  parameter int ET          = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_exact,
  output logic [WIDTH:0]   out_err,
  output logic             out_viol,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [WIDTH:0]   max_err
);

  localparam int K = APPROX_BITS;
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  // Low K bits set; K=0 gives an all-zero mask, K=WIDTH covers every operand bit.
  localparam logic [WIDTH:0] LO_MASK = (ONE << K) - ONE;
  // Threshold is assumed to fit in WIDTH+1 bits.
  localparam logic [WIDTH:0] ET_V = (WIDTH+1)'(ET);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_adv;
  logic             s2_adv;
  logic             cin;
  logic [WIDTH:0]   a_x;
  logic [WIDTH:0]   b_x;
  logic [WIDTH:0]   approx_c;
  logic [WIDTH:0]   exact_c;
  logic [WIDTH:0]   err_c;
  logic             viol_c;
  logic             out_hs;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = out_valid && out_ready;

  // Carry into the exact upper part comes from the top approximated bit pair.
  if (K > 0) begin : g_cin
    assign cin = s1_a[K-1] & s1_b[K-1];
  end else begin : g_no_cin
    assign cin = 1'b0;
  end

  // Approximate, exact and error arithmetic on the S1 operands.
  always_comb begin
    a_x      = {1'b0, s1_a};
    b_x      = {1'b0, s1_b};
    // Upper part is added exactly with its low K bits forced to zero, so the
    // OR with the lower part never overlaps.
    approx_c = ((a_x & ~LO_MASK) + (b_x & ~LO_MASK) + ({{WIDTH{1'b0}}, cin} << K))
             | ((a_x | b_x) & LO_MASK);
    exact_c  = a_x + b_x;
    err_c    = (exact_c >= approx_c) ? (exact_c - approx_c) : (approx_c - exact_c);
    viol_c   = err_c > ET_V;
  end

  // Stage 1: operand capture on input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
    end
  end

  // Stage 2: result registers, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_exact <= '0;
      out_err   <= '0;
      out_viol  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum   <= approx_c;
        out_exact <= exact_c;
        out_err   <= err_c;
        out_viol  <= viol_c;
      end
    end
  end

  // Statistics over delivered samples; clr wins over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      viol_cnt   <= '0;
      max_err    <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      viol_cnt   <= '0;
      max_err    <= '0;
    end else if (out_hs) begin
      if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
      if (out_viol && (viol_cnt != '1)) viol_cnt <= viol_cnt + 1'b1;
      if (out_err > max_err) max_err <= out_err;
    end
  end

endmodule

// File: tb/tb_approx_adder_pipe_errmon.sv
// tb_approx_adder_pipe_errmon
// Four configurations share one stimulus stream and stay in lockstep:
//   0: K=2 CNT_W=16   1: K=3 CNT_W=16   2: K=2 CNT_W=3   3: K=0 CNT_W=16
// Reference: arithmetic model of the approximate sum plus an occupancy model
// of the two-deep pipe driven by an expected queue of accepted operand pairs.
module tb_approx_adder_pipe_errmon;

  localparam int W  = 8;
  localparam int ET = 2;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic out_ready;
  logic clr;

  logic         i_ready [N];
  logic         o_valid [N];
  logic [W:0]   o_sum   [N];
  logic [W:0]   o_exact [N];
  logic [W:0]   o_err   [N];
  logic         o_viol  [N];
  logic [15:0]  s_cnt   [N];
  logic [15:0]  v_cnt   [N];
  logic [W:0]   max_e   [N];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int KG = (g == 1) ? 3 : (g == 3) ? 0 : 2;
    localparam int CW = (g == 2) ? 3 : 16;
    logic [CW-1:0] sc;
    logic [CW-1:0] vc;
    approx_adder_pipe_errmon #(.WIDTH(W), .APPROX_BITS(KG), .ET(ET), .CNT_W(CW)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i_ready[g]),
      .in_a(in_a), .in_b(in_b), .clr(clr), .out_valid(o_valid[g]),
      .out_ready(out_ready), .out_sum(o_sum[g]), .out_exact(o_exact[g]),
      .out_err(o_err[g]), .out_viol(o_viol[g]), .sample_cnt(sc),
      .viol_cnt(vc), .max_err(max_e[g])
    );
    assign s_cnt[g] = 16'(sc);
    assign v_cnt[g] = 16'(vc);
  end

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int tag_q[$];
  int ec;
  int m_scnt [N];
  int m_vcnt [N];
  int m_max  [N];
  int n_vec;
  int n_err;

  function automatic int k_of(input int g);
    return (g == 1) ? 3 : (g == 3) ? 0 : 2;
  endfunction

  function automatic int cnt_max(input int g);
    return (g == 2) ? 7 : 65535;
  endfunction

  // Approximate sum from its definition: OR the low k bits, add the rest
  // exactly with the carry generated by the top approximated bit pair.
  function automatic int ref_sum(input int a, input int b, input int k);
    int lo, hi, cin;
    if (k == 0) return a + b;
    lo  = (a | b) % (1 << k);
    cin = ((a >> (k - 1)) & 1) & ((b >> (k - 1)) & 1);
    hi  = (a >> k) + (b >> k) + cin;
    return hi * (1 << k) + lo;
  endfunction

  function automatic int ref_err(input int a, input int b, input int k);
    int s;
    s = ref_sum(a, b, k);
    return (a + b >= s) ? (a + b - s) : (s - (a + b));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int g = 0; g < N; g++) begin
      m_scnt[g] = 0;
      m_vcnt[g] = 0;
      m_max[g]  = 0;
    end
  endtask

  task automatic check_stats();
    for (int g = 0; g < N; g++) begin
      check($sformatf("sample_cnt%0d", g), 32'(s_cnt[g]), 32'(m_scnt[g]));
      check($sformatf("viol_cnt%0d", g), 32'(v_cnt[g]), 32'(m_vcnt[g]));
      check($sformatf("max_err%0d", g), 32'(max_e[g]), 32'(m_max[g]));
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ordy, input logic c, output logic hs_in);
    logic exp_ov, exp_ir, hs_out;
    int ha, hb;
    in_valid = v; in_a = a; in_b = b; out_ready = ordy; clr = c;
    #1;
    exp_ov = (exp_q.size() > 0) && (ec >= tag_q[0] + 1);
    exp_ir = (exp_q.size() < 2) || ordy;
    ha = 0; hb = 0;
    if (exp_q.size() > 0) begin
      ha = int'(exp_q[0][2*W-1:W]);
      hb = int'(exp_q[0][W-1:0]);
    end
    for (int g = 0; g < N; g++) begin
      check($sformatf("out_valid%0d", g), 32'(o_valid[g]), 32'(exp_ov));
      check($sformatf("in_ready%0d", g), 32'(i_ready[g]), 32'(exp_ir));
      if (exp_ov) begin
        check($sformatf("sum%0d", g), 32'(o_sum[g]), 32'(ref_sum(ha, hb, k_of(g))));
        check($sformatf("exact%0d", g), 32'(o_exact[g]), 32'(ha + hb));
        check($sformatf("err%0d", g), 32'(o_err[g]), 32'(ref_err(ha, hb, k_of(g))));
        check($sformatf("viol%0d", g), 32'(o_viol[g]), 32'(ref_err(ha, hb, k_of(g)) > ET));
      end
    end
    hs_out = exp_ov && ordy;
    hs_in  = v && exp_ir;
    @(posedge clk);
    if (c) clear_model();
    else if (hs_out) begin
      for (int g = 0; g < N; g++) begin
        int e;
        e = ref_err(ha, hb, k_of(g));
        if (m_scnt[g] < cnt_max(g)) m_scnt[g]++;
        if (e > ET && m_vcnt[g] < cnt_max(g)) m_vcnt[g]++;
        if (e > m_max[g]) m_max[g] = e;
      end
    end
    if (hs_out) begin
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end
    ec++;
    if (hs_in) begin
      exp_q.push_back({a, b});
      tag_q.push_back(ec);
    end
    @(negedge clk);
    check_stats();
  endtask

  task automatic drain();
    logic hs;
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0, hs);
      budget--;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic hs;
    int pushed, budget;
    logic pat [4];
    n_vec = 0; n_err = 0; ec = 0;
    clear_model();
    rst_n = 1'b0; in_valid = 1'b1; in_a = 8'hff; in_b = 8'hff; out_ready = 1'b1; clr = 1'b0;

    // Reset held with in_valid asserted: everything stays zero.
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst_valid%0d", g), 32'(o_valid[g]), 0);
      check($sformatf("rst_ready%0d", g), 32'(i_ready[g]), 1);
      check($sformatf("rst_sum%0d", g), 32'(o_sum[g]), 0);
      check($sformatf("rst_exact%0d", g), 32'(o_exact[g]), 0);
      check($sformatf("rst_err%0d", g), 32'(o_err[g]), 0);
      check($sformatf("rst_viol%0d", g), 32'(o_viol[g]), 0);
    end
    check_stats();
    rst_n = 1'b1;

    // Directed vectors and latency.
    cycle(1'b1, 8'h03, 8'h03, 1'b1, 1'b0, hs);
    check("lat_edge1", 32'(o_valid[0]), 0);
    cycle(1'b1, 8'h02, 8'h02, 1'b1, 1'b0, hs);
    check("lat_edge2", 32'(o_valid[0]), 1);
    check("k2_3p3_sum", 32'(o_sum[0]), 7);
    check("k2_3p3_err", 32'(o_err[0]), 1);
    cycle(1'b1, 8'h05, 8'h05, 1'b1, 1'b0, hs);
    check("k2_2p2_sum", 32'(o_sum[0]), 6);
    check("k2_2p2_viol", 32'(o_viol[0]), 0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, hs);
    check("k3_5p5_sum", 32'(o_sum[1]), 13);
    check("k3_5p5_err", 32'(o_err[1]), 3);
    check("k3_5p5_viol", 32'(o_viol[1]), 1);
    drain();

    // Back-to-back 8 pairs with out_ready toggling 1,0,0,1.
    cycle(1'b0, '0, '0, 1'b1, 1'b1, hs);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    pushed = 0; budget = 60;
    for (int i = 0; pushed < 8 && budget > 0; i++) begin
      cycle(1'b1, W'($urandom), W'($urandom), pat[i % 4], 1'b0, hs);
      if (hs) pushed++;
      budget--;
    end
    check("stream_pushed", 32'(pushed), 8);
    drain();
    check("stream_sample_cnt", 32'(s_cnt[0]), 8);

    // Saturation on the 3-bit counters, then clr against a delivery.
    cycle(1'b0, '0, '0, 1'b1, 1'b1, hs);
    for (int i = 0; i < 10; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0, hs);
    drain();
    check("sat_sample_cnt", 32'(s_cnt[2]), 7);
    cycle(1'b1, 8'h81, 8'h42, 1'b0, 1'b0, hs);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, hs);
    check("clr_pre_valid", 32'(o_valid[2]), 1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1, hs);
    check("clr_sample_cnt", 32'(s_cnt[2]), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 1000; i++)
      cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
            $urandom_range(0, 2) != 0, 1'b0, hs);
    drain();
    check("k0_viol_cnt", 32'(v_cnt[3]), 0);
    check("k0_max_err", 32'(max_e[3]), 0);

    // Reset in the middle of a stream discards in-flight samples.
    cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, hs);
    cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, hs);
    #3 rst_n = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      check($sformatf("midrst_valid%0d", g), 32'(o_valid[g]), 0);
      check($sformatf("midrst_cnt%0d", g), 32'(s_cnt[g]), 0);
    end
    exp_q.delete();
    tag_q.delete();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'hf0, 8'h0f, 1'b1, 1'b0, hs);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    n_err++;
    $display("FAIL timeout: simulation did not reach the end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/approx_adder_pipe_errmon.md
Name: approx_adder_pipe_errmon

Overview:
Parametrised, pipelined successor to the fixed 2-bit SOP-approximated adders. Adds two WIDTH-bit operands with a lower-part-OR approximation of the APPROX_BITS LSBs and computes the exact sum in parallel. Reports per-sample error magnitude and threshold violation, and keeps running statistics. Used on hardware to validate error-threshold (ET) claims for approximated adder candidates under streaming stimulus with valid/ready flow control.

Parameters:
WIDTH, 8, operand width in bits (>=2)
APPROX_BITS, 2, number of LSBs approximated (0..WIDTH); 0 = exact adder
ET, 2, error threshold; violation when err > ET
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
clr  in  1  synchronous clear of statistics
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sum  out  WIDTH+1  approximate sum
out_exact  out  WIDTH+1  exact sum
out_err  out  WIDTH+1  |exact - approx|
out_viol  out  1  out_err > ET
sample_cnt  out  CNT_W  accepted output samples
viol_cnt  out  CNT_W  accepted samples with out_viol=1
max_err  out  WIDTH+1  largest out_err among accepted samples

Behaviour:
- Reset (rst_n=0, async): all valid flags, counters, max_err and every output register = 0; in_ready = 1 combinationally after reset.
- Two register stages. S1 captures in_a/in_b on in_valid&&in_ready. S2 holds the computed results. Latency = 2 clocks from input handshake to out_valid with no backpressure. Throughput = 1 sample/clock.
- Flow control: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no bubble).
- Under stall (out_valid && !out_ready), all S2 outputs hold stable; no data loss or duplication.
- Arithmetic (K = APPROX_BITS):
  - approx[K-1:0] = a[K-1:0] | b[K-1:0].
  - cin = a[K-1] & b[K-1] when K>0, else 0.
  - approx[WIDTH:K] = a[WIDTH-1:K] + b[WIDTH-1:K] + cin, zero-extended.
  - K=WIDTH: approx[WIDTH] = cin.
  - exact = a + b, WIDTH+1 bits.
  - err = exact >= approx ? exact - approx : approx - exact.
  - viol = err > ET; equality is not a violation.
- Statistics update only on output handshake (out_valid && out_ready):
  - sample_cnt += 1; viol_cnt += out_viol.
  - Both counters saturate at all-ones; no wrap.
  - max_err = max(max_err, out_err).
- clr: synchronous; zeroes sample_cnt, viol_cnt and max_err. It has priority over a same-cycle handshake (that sample is not counted). Pipeline data is unaffected.
- Reset mid-stream: in-flight samples are discarded; out_valid drops asynchronously.
- K=0: out_err is always 0 and out_viol is always 0.

Test Plan:
- Reset with in_valid=1 held -> all outputs 0; after release, first result appears exactly 2 clocks after the first handshake.
- Defaults (W=8, K=2, ET=2), out_ready=1:
  - a=0x03, b=0x03 -> exact=6, sum=7, err=1, viol=0.
  - a=0x02, b=0x02 -> exact=4, sum=6, err=2, viol=0 (boundary).
- APPROX_BITS=3: a=0x05, b=0x05 -> exact=10, sum=13, err=3, viol=1; viol_cnt=1, max_err=3.
- Back-to-back stream of 8 pairs with out_ready toggling 1,0,0,1 -> every result delivered once, in order, values held while stalled; sample_cnt=8.
- Saturation with CNT_W=3: 10 accepted samples -> sample_cnt=7. clr asserted together with a handshake -> sample_cnt=0 next cycle.
- APPROX_BITS=0: random 1000 pairs -> out_sum==out_exact, viol_cnt=0, max_err=0.
